// File: rtl/mux_pkg.sv
// Shared definitions for the mux family: arbiter state encoding and a
// width helper usable in constant expressions.
package mux_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Ceiling log2; returns 0 for values 0 and 1, so callers clamp widths themselves.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the arbiter, its requesters and the shared mux select.
interface mux_rr_arbiter_if #(
   parameter int SELECT_LINES = 4
);
   localparam int N = 2**SELECT_LINES;

   logic [N-1:0]            req;
   logic [N-1:0]            grant;
   logic [SELECT_LINES-1:0] select;
   logic                    valid;

   modport master (
      input  req,
      output grant,
      output select,
      output valid
   );

   modport slave (
      output req,
      input  grant,
      input  select,
      input  valid
   );

endinterface

// File: rtl/mux_rr_arbiter_rr_priority_encoder.sv
// Round-robin find-first: the request just after `last` wins, wrapping
// through N-1 -> 0 -> last.
module rr_priority_encoder #(
   parameter  int SELECT_LINES = 4,
   localparam int N            = 2**SELECT_LINES
) (
   input  logic [N-1:0]            req_i,
   input  logic [SELECT_LINES-1:0] last_i,
   output logic                    any_o,
   output logic [SELECT_LINES-1:0] idx_o
);

   logic [2*N-1:0]          dbl;
   logic [N-1:0]            rot;
   logic [SELECT_LINES-1:0] off;

   // Rotating the doubled vector puts index last+1 at bit 0, so the lowest
   // set bit of rot is the offset of the winner from last+1.
   always_comb begin
      dbl = {req_i, req_i};
      rot = N'(dbl >> ({1'b0, last_i} + 1'b1));
      off = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (rot[i]) off = SELECT_LINES'(i);
      end
   end

   assign any_o = |req_i;
   assign idx_o = last_i + off + 1'b1;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner for a shared mux: drives select directly, gives one-hot
// grant feedback and bounds each tenure by MAX_HOLD while others wait.
module mux_rr_arbiter
   import mux_pkg::*;
#(
   parameter      BLOCK_NAME   = "mux_rr_arbiter",
   parameter int  X            = 0,
   parameter int  Y            = 0,
   parameter int  DX           = 0,
   parameter int  DY           = 0,
   parameter      ARCHITECTURE = "BEHAVIORAL",
   parameter int  SELECT_LINES = 4,
   parameter int  MAX_HOLD     = 16
) (
   input logic              clk,
   input logic              rst_n,
   mux_rr_arbiter_if.master arb
);

   localparam int N  = 2**SELECT_LINES;
   localparam int HW = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   state_e                  state_q, state_d;
   logic [SELECT_LINES-1:0] own_q, own_d;
   logic [SELECT_LINES-1:0] last_q, last_d;
   logic [HW-1:0]           hold_q, hold_d;
   logic [N-1:0]            grant_q, grant_d;

   logic [SELECT_LINES-1:0] base;
   logic [SELECT_LINES-1:0] win_idx;
   logic                    win_any;
   logic                    owner_req;
   logic                    others;
   logic                    hold_expired;

   // While busy the search starts after the current owner, which puts the
   // owner last in rotation for both a drop and a hold-limit handoff.
   assign base = (state_q == ST_BUSY) ? own_q : last_q;

   rr_priority_encoder #(
      .SELECT_LINES(SELECT_LINES)
   ) u_prio (
      .req_i (arb.req),
      .last_i(base),
      .any_o (win_any),
      .idx_o (win_idx)
   );

   assign owner_req    = arb.req[own_q];
   assign others       = |(arb.req & ~(N'(1) << own_q));
   assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      last_d  = last_q;
      hold_d  = hold_q;
      grant_d = grant_q;
      case (state_q)
         ST_IDLE: begin
            if (win_any) begin
               state_d = ST_BUSY;
               own_d   = win_idx;
               hold_d  = '0;
               grant_d = N'(1) << win_idx;
            end
         end
         ST_BUSY: begin
            if (!owner_req) begin
               last_d = own_q;
               hold_d = '0;
               if (win_any) begin
                  own_d   = win_idx;
                  grant_d = N'(1) << win_idx;
               end else begin
                  state_d = ST_IDLE;
                  grant_d = '0;
               end
            end else if (hold_expired && others) begin
               last_d  = own_q;
               own_d   = win_idx;
               hold_d  = '0;
               grant_d = N'(1) << win_idx;
            end else if (hold_expired) begin
               hold_d = '0;
            end else if (MAX_HOLD != 0) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         own_q   <= '0;
         last_q  <= '0;
         hold_q  <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
      end
   end

   // select holds the last owner while idle; only valid qualifies it.
   assign arb.grant  = grant_q;
   assign arb.select = own_q;
   assign arb.valid  = (state_q == ST_BUSY);

endmodule
